// File: rtl/mod_arbiter.sv
// mod_arbiter: shares one modulo unit between two requesters. It arbitrates
// round-robin, runs one transaction at a time through IDLE -> ISSUE -> WAIT ->
// FLUSH -> RESP, resets the modulo unit after every transaction and returns
// the remainder (or an error) to the requester that owns the grant.
module mod_arbiter #(
  parameter int SIZE    = 128,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  // requester 0
  input  logic [SIZE-1:0] req0_dividen_tdata,
  input  logic [SIZE-1:0] req0_divisor_tdata,
  input  logic            req0_tvalid,
  output logic            req0_tready,
  output logic [SIZE-1:0] res0_tdata,
  output logic            res0_tuser,
  output logic            res0_tvalid,
  input  logic            res0_tready,
  // requester 1
  input  logic [SIZE-1:0] req1_dividen_tdata,
  input  logic [SIZE-1:0] req1_divisor_tdata,
  input  logic            req1_tvalid,
  output logic            req1_tready,
  output logic [SIZE-1:0] res1_tdata,
  output logic            res1_tuser,
  output logic            res1_tvalid,
  input  logic            res1_tready,
  // shared modulo unit
  output logic [SIZE-1:0] mod_dividen_tdata,
  output logic            mod_dividen_tvalid,
  input  logic            mod_dividen_tready,
  output logic [SIZE-1:0] mod_divisor_tdata,
  output logic            mod_divisor_tvalid,
  input  logic            mod_divisor_tready,
  input  logic [SIZE-1:0] mod_result_tdata,
  input  logic            mod_result_tvalid,
  output logic            mod_result_tready,
  output logic            mod_rst,
  // status
  output logic            busy,
  output logic            grant_id
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FLUSH,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            grant_q, grant_d;
  logic [SIZE-1:0] dvd_q, dvd_d;
  logic [SIZE-1:0] dvs_q, dvs_d;
  logic [SIZE-1:0] res_data_q, res_data_d;
  logic            res_user_q, res_user_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            flush_q, flush_d;
  logic            dvd_done_q, dvd_done_d;
  logic            dvs_done_q, dvs_done_d;

  logic            any_req;
  logic            winner;
  logic            accept;
  logic [SIZE-1:0] sel_dvd;
  logic [SIZE-1:0] sel_dvs;
  logic            dvd_hs;
  logic            dvs_hs;
  logic            res_ready_sel;

  // Round-robin arbitration: a lone requester wins, a tie goes to whoever did not win last.
  assign any_req = req0_tvalid | req1_tvalid;
  assign winner  = (req0_tvalid & req1_tvalid) ? ~last_grant_q : req1_tvalid;
  assign accept  = (state_q == S_IDLE) & any_req;
  assign sel_dvd = winner ? req1_dividen_tdata : req0_dividen_tdata;
  assign sel_dvs = winner ? req1_divisor_tdata : req0_divisor_tdata;

  assign req0_tready = accept & ~winner;
  assign req1_tready = accept &  winner;

  // Each operand channel drops its valid independently once it has been taken.
  assign mod_dividen_tdata  = dvd_q;
  assign mod_divisor_tdata  = dvs_q;
  assign mod_dividen_tvalid = (state_q == S_ISSUE) & ~dvd_done_q;
  assign mod_divisor_tvalid = (state_q == S_ISSUE) & ~dvs_done_q;
  assign dvd_hs             = mod_dividen_tvalid & mod_dividen_tready;
  assign dvs_hs             = mod_divisor_tvalid & mod_divisor_tready;
  assign mod_result_tready  = (state_q == S_WAIT);

  // The modulo unit is held in reset during our own reset and while flushing.
  assign mod_rst = rst | (state_q == S_FLUSH);

  assign res0_tdata    = res_data_q;
  assign res1_tdata    = res_data_q;
  assign res0_tuser    = res_user_q;
  assign res1_tuser    = res_user_q;
  assign res0_tvalid   = (state_q == S_RESP) & ~grant_q;
  assign res1_tvalid   = (state_q == S_RESP) &  grant_q;
  assign res_ready_sel = grant_q ? res1_tready : res0_tready;

  assign busy     = (state_q != S_IDLE);
  assign grant_id = grant_q;

  // Next-state logic for the transaction FSM and its datapath registers.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    dvd_d        = dvd_q;
    dvs_d        = dvs_q;
    res_data_d   = res_data_q;
    res_user_d   = res_user_q;
    cnt_d        = cnt_q;
    flush_d      = flush_q;
    dvd_done_d   = dvd_done_q;
    dvs_done_d   = dvs_done_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          grant_d    = winner;
          dvd_d      = sel_dvd;
          dvs_d      = sel_dvs;
          dvd_done_d = 1'b0;
          dvs_done_d = 1'b0;
          cnt_d      = '0;
          flush_d    = 1'b0;
          if (sel_dvs == '0) begin
            // Division by zero never reaches the modulo unit.
            res_data_d = '0;
            res_user_d = 1'b1;
            state_d    = S_FLUSH;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        dvd_done_d = dvd_done_q | dvd_hs;
        dvs_done_d = dvs_done_q | dvs_hs;
        if (dvd_done_d && dvs_done_d) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mod_result_tvalid) begin
          res_data_d = mod_result_tdata;
          res_user_d = 1'b0;
          state_d    = S_FLUSH;
        end else if (cnt_q == CNT_LAST) begin
          res_data_d = '0;
          res_user_d = 1'b1;
          state_d    = S_FLUSH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FLUSH: begin
        // Two cycles: flush_q marks the second one.
        flush_d = 1'b1;
        if (flush_q) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (res_ready_sel) begin
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      res_data_q   <= '0;
      res_user_q   <= 1'b0;
      cnt_q        <= '0;
      flush_q      <= 1'b0;
      dvd_done_q   <= 1'b0;
      dvs_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      res_data_q   <= res_data_d;
      res_user_q   <= res_user_d;
      cnt_q        <= cnt_d;
      flush_q      <= flush_d;
      dvd_done_q   <= dvd_done_d;
      dvs_done_q   <= dvs_done_d;
    end
  end

  // Operand latches, loaded only on the request handshake.
  always_ff @(posedge clk) begin
    // NOTE: no reset here; these are only observed after being loaded in ISSUE.
    dvd_q <= dvd_d;
    dvs_q <= dvs_d;
  end

endmodule
